control_unit_faster: RTL and testbench
======================================

// Module: control_unit_faster
// PURPOSE
//  Main FSM control unit of the multicycle 16-bit CPU; sits beside the datapath.
//  Decodes the 4-bit opcode from the instruction register and drives every datapath enable and mux select.
//  The "faster" variant uses only three states (FETCH, EXEC, MEM), so ALU/branch/store/push/call retire in 2 cycles plus fetch wait.
// PARAMETERS
//  None. Opcode width is fixed at 4, and the ALUOp and RWSrc widths are fixed at 3.
// PORTS
//  CLK     in   1  system clock, rising edge
//  Reset   in   1  synchronous, active-high reset
//  Op      in   4  opcode from instruction register, stable from EXEC on
//  LMC     in   1  load-memory-complete: read data valid this cycle
//  Perform in   1  branch condition true (from flag logic)
//  PCW     out  1  PC write enable
//  Jump    out  1  PC source: 0=PC+1; 1=target (memory read data when LM=1)
//  MW      out  1  memory write strobe (single cycle, no handshake)
//  LM      out  1  memory read request, held until LMC
//  IW      out  1  instruction register write
//  IorD    out  1  memory address: 0=PC, 1=ALU result
//  MSrc    out  1  memory write data: 0=register, 1=PC
//  RW      out  1  register file write
//  RWSrc   out  3  writeback: 000 ALU, 001 mem data, 010 immediate, 011 PC, 100 SP
//  ALUOp   out  3  000 ADD/SP+1, 001 SUB/SP-1, 010 AND, 011 OR, 101 SHL
//  SrcB    out  1  ALU B operand: 0=register, 1=immediate
//  FU      out  1  flag register update
//  SPW     out  1  stack pointer write; ALUOp 000 increments, 001 decrements
//  SPIorD  out  1  memory address from SP (overrides IorD)
// BEHAVIOUR
//  - State register encoding: FETCH=00, EXEC=01, MEM=10. Illegal 11 -> FETCH on the next edge.
//  - Reset=1 at a clock edge: state <= FETCH. All outputs are forced to 0 while Reset is high, even mid-instruction.
//  - Outputs are combinational from state, Op, LMC and Perform. Unlisted outputs are 0.
//  - FETCH: LM=1, IorD=0.
//    - While LMC=0: stay in FETCH.
//    - When LMC=1: IW=1, PCW=1, Jump=0, then go to EXEC.
//  - EXEC, by Op. Every op returns to FETCH unless a row says MEM.
//    - 0 NOP: no outputs asserted.
//    - 1 ADD / 2 SUB / 3 AND / 4 OR: RW=1, RWSrc=000, FU=1, SrcB=0; ALUOp=000/001/010/011.
//    - 5 ADDI: RW=1, FU=1, SrcB=1, ALUOp=000.
//    - 6 SHL: RW=1, FU=1, SrcB=1, ALUOp=101.
//    - 7 LI: RW=1, RWSrc=010.
//    - 8 LW: ALUOp=000, SrcB=1, then go to MEM.
//    - 9 SW: MW=1, IorD=1, MSrc=0, ALUOp=000, SrcB=1.
//    - A BR: Jump=1, PCW=Perform.
//    - B J: Jump=1, PCW=1.
//    - C CALL: MW=1, SPIorD=1, MSrc=1, SPW=1, ALUOp=001, PCW=1, Jump=1. Pushes PC+1, then jumps.
//    - D RET / F POP: SPW=1, ALUOp=000, then go to MEM.
//    - E PUSH: MW=1, SPIorD=1, MSrc=0, SPW=1, ALUOp=001.
//  - Stack convention: push writes mem[SP] then SP--; pop does SP++ then reads mem[SP].
//  - MEM: LM=1 and Op decides the rest. Hold in MEM while LMC=0.
//    - LW: IorD=1, ALUOp=000, SrcB=1. On LMC=1: RW=1, RWSrc=001.
//    - POP: SPIorD=1. On LMC=1: RW=1, RWSrc=001.
//    - RET: SPIorD=1. On LMC=1: PCW=1, Jump=1 (PC <- read data).
//  - Any other Op in MEM is unreachable; if reached, go to FETCH with no outputs asserted.
//  - LMC arriving in the same cycle LM rises is valid (zero-wait memory). LMC outside FETCH/MEM is ignored.
//  - Latency with zero-wait memory:
//    - ALU ops, branches, stores, push, call: 2 cycles.
//    - LW, POP, RET: 3 cycles.
// CONFIGURATION
//  - CU_SYNC_MEM_EN defined: LMC is ignored and treated as 1. FETCH and MEM each last exactly one cycle.
//  - CU_SYNC_MEM_EN undefined: FETCH and MEM wait on the LMC handshake as described above.
// TESTING
//  - Reset high 2 cycles with Op=8 and LMC=1 -> all outputs 0. After release: FETCH with LM=1, IorD=0.
//  - FETCH, LMC=0 for 3 cycles then 1 -> LM held 4 cycles; IW=PCW=1 only in the 4th; then EXEC.
//  - Op=1 in EXEC -> RW=1, RWSrc=000, ALUOp=000, FU=1, SrcB=0 for one cycle; next state FETCH.
//  - Op=A: Perform=0 -> PCW=0, Jump=1. Perform=1 -> PCW=1, Jump=1.
//  - Op=D, then LMC=1 after 2 wait cycles -> EXEC: SPW=1, ALUOp=000. MEM: LM=1, SPIorD=1 for 3 cycles; PCW=Jump=1 in the last.
//  - Op=C -> MW=SPW=SPIorD=MSrc=PCW=Jump=1, ALUOp=001 in one cycle. With CU_SYNC_MEM_EN: fetch takes 1 cycle regardless of LMC.

Source files
------------

// File: rtl/control_unit_faster.sv
// Three-state (FETCH/EXEC/MEM) control FSM for the multicycle 16-bit CPU.
// Define CU_SYNC_MEM_EN to treat LMC as always 1 (single-cycle FETCH and MEM).
module control_unit_faster (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [3:0] Op,
   input  logic       LMC,
   input  logic       Perform,
   output logic       PCW,
   output logic       Jump,
   output logic       MW,
   output logic       LM,
   output logic       IW,
   output logic       IorD,
   output logic       MSrc,
   output logic       RW,
   output logic [2:0] RWSrc,
   output logic [2:0] ALUOp,
   output logic       SrcB,
   output logic       FU,
   output logic       SPW,
   output logic       SPIorD
);

   typedef enum logic [1:0] {
      FETCH = 2'b00,
      EXEC  = 2'b01,
      MEM   = 2'b10
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_LI   = 4'h7;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_BR   = 4'hA;
   localparam logic [3:0] OP_J    = 4'hB;
   localparam logic [3:0] OP_CALL = 4'hC;
   localparam logic [3:0] OP_RET  = 4'hD;
   localparam logic [3:0] OP_PUSH = 4'hE;
   localparam logic [3:0] OP_POP  = 4'hF;

   state_t state;
   state_t nxt;
   logic   lmc;

`ifdef CU_SYNC_MEM_EN
   logic unused_lmc;
   assign unused_lmc = LMC;
   assign lmc = 1'b1;
`else
   assign lmc = LMC;
`endif

   always_ff @(posedge CLK) begin
      if (Reset)
         state <= FETCH;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH: nxt = lmc ? EXEC : FETCH;
         EXEC: begin
            if (Op == OP_LW || Op == OP_RET || Op == OP_POP)
               nxt = MEM;
         end
         MEM: begin
            if ((Op == OP_LW || Op == OP_RET || Op == OP_POP) && !lmc)
               nxt = MEM;
         end
         default: nxt = FETCH;
      endcase
   end

   always_comb begin
      PCW    = 1'b0;
      Jump   = 1'b0;
      MW     = 1'b0;
      LM     = 1'b0;
      IW     = 1'b0;
      IorD   = 1'b0;
      MSrc   = 1'b0;
      RW     = 1'b0;
      RWSrc  = 3'b000;
      ALUOp  = 3'b000;
      SrcB   = 1'b0;
      FU     = 1'b0;
      SPW    = 1'b0;
      SPIorD = 1'b0;
      if (!Reset) begin
         case (state)
            FETCH: begin
               LM = 1'b1;
               if (lmc) begin
                  IW  = 1'b1;
                  PCW = 1'b1;
               end
            end
            EXEC: begin
               case (Op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     RW    = 1'b1;
                     FU    = 1'b1;
                     ALUOp = {1'b0, Op[1:0] - 2'd1};
                  end
                  OP_ADDI: begin
                     RW   = 1'b1;
                     FU   = 1'b1;
                     SrcB = 1'b1;
                  end
                  OP_SHL: begin
                     RW    = 1'b1;
                     FU    = 1'b1;
                     SrcB  = 1'b1;
                     ALUOp = 3'b101;
                  end
                  OP_LI: begin
                     RW    = 1'b1;
                     RWSrc = 3'b010;
                  end
                  OP_LW: SrcB = 1'b1;
                  OP_SW: begin
                     MW   = 1'b1;
                     IorD = 1'b1;
                     SrcB = 1'b1;
                  end
                  OP_BR: begin
                     Jump = 1'b1;
                     PCW  = Perform;
                  end
                  OP_J: begin
                     Jump = 1'b1;
                     PCW  = 1'b1;
                  end
                  // push PC+1 at SP, decrement SP and jump, all in one cycle
                  OP_CALL: begin
                     MW     = 1'b1;
                     SPIorD = 1'b1;
                     MSrc   = 1'b1;
                     SPW    = 1'b1;
                     ALUOp  = 3'b001;
                     PCW    = 1'b1;
                     Jump   = 1'b1;
                  end
                  OP_RET, OP_POP: SPW = 1'b1;
                  OP_PUSH: begin
                     MW     = 1'b1;
                     SPIorD = 1'b1;
                     SPW    = 1'b1;
                     ALUOp  = 3'b001;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               case (Op)
                  OP_LW: begin
                     LM   = 1'b1;
                     IorD = 1'b1;
                     SrcB = 1'b1;
                     if (lmc) begin
                        RW    = 1'b1;
                        RWSrc = 3'b001;
                     end
                  end
                  OP_POP: begin
                     LM     = 1'b1;
                     SPIorD = 1'b1;
                     if (lmc) begin
                        RW    = 1'b1;
                        RWSrc = 3'b001;
                     end
                  end
                  OP_RET: begin
                     LM     = 1'b1;
                     SPIorD = 1'b1;
                     if (lmc) begin
                        PCW  = 1'b1;
                        Jump = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit_faster.sv
// Scoreboard bench for control_unit_faster: expected output vectors are
// queued as stimulus is driven and popped when outputs are sampled.
module tb_control_unit_faster;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] Op = 4'h8;
   logic       LMC = 1'b1;
   logic       Perform = 1'b0;
   logic       PCW, Jump, MW, LM, IW, IorD, MSrc, RW;
   logic [2:0] RWSrc, ALUOp;
   logic       SrcB, FU, SPW, SPIorD;

   control_unit_faster dut (
      .CLK(CLK), .Reset(Reset), .Op(Op), .LMC(LMC), .Perform(Perform),
      .PCW(PCW), .Jump(Jump), .MW(MW), .LM(LM), .IW(IW), .IorD(IorD),
      .MSrc(MSrc), .RW(RW), .RWSrc(RWSrc), .ALUOp(ALUOp), .SrcB(SrcB),
      .FU(FU), .SPW(SPW), .SPIorD(SPIorD)
   );

   always #5 CLK = ~CLK;

   // {PCW,Jump,MW,LM,IW,IorD,MSrc,RW,RWSrc[2:0],ALUOp[2:0],SrcB,FU,SPW,SPIorD}
   localparam logic [17:0] B_PCW  = 18'h1 << 17;
   localparam logic [17:0] B_JMP  = 18'h1 << 16;
   localparam logic [17:0] B_MW   = 18'h1 << 15;
   localparam logic [17:0] B_LM   = 18'h1 << 14;
   localparam logic [17:0] B_IW   = 18'h1 << 13;
   localparam logic [17:0] B_IORD = 18'h1 << 12;
   localparam logic [17:0] B_MSRC = 18'h1 << 11;
   localparam logic [17:0] B_RW   = 18'h1 << 10;
   localparam logic [17:0] B_SRCB = 18'h1 << 3;
   localparam logic [17:0] B_FU   = 18'h1 << 2;
   localparam logic [17:0] B_SPW  = 18'h1 << 1;
   localparam logic [17:0] B_SPA  = 18'h1;

   function automatic logic [17:0] rws(input logic [2:0] v);
      return {8'h00, v, 7'h00};
   endfunction

   function automatic logic [17:0] alu(input logic [2:0] v);
      return {11'h000, v, 4'h0};
   endfunction

   logic [17:0] exp_q[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [17:0] got,
                        input logic [17:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic [3:0] op,
                       input logic lmc, input logic perf,
                       input logic [17:0] exp);
      logic [17:0] got;
      @(posedge CLK);
      #1;
      Reset = rst;
      Op = op;
      LMC = lmc;
      Perform = perf;
      exp_q.push_back(exp);
      @(negedge CLK);
      got = {PCW, Jump, MW, LM, IW, IorD, MSrc, RW, RWSrc, ALUOp,
             SrcB, FU, SPW, SPIorD};
      if (exp_q.size() == 0)
         check({tag, "_empty"}, got, 18'h3ffff ^ got);
      else
         check(tag, got, exp_q.pop_front());
   endtask

   task automatic fetch(input string tag, input logic [3:0] op, input int nwait);
`ifdef CU_SYNC_MEM_EN
      if (nwait > 0)
         step({tag, "_f"}, 1'b0, op, 1'b0, 1'b0, B_LM | B_IW | B_PCW);
      else
         step({tag, "_f"}, 1'b0, op, 1'b1, 1'b0, B_LM | B_IW | B_PCW);
`else
      for (int i = 0; i < nwait; i++)
         step({tag, "_fw"}, 1'b0, op, 1'b0, 1'b0, B_LM);
      step({tag, "_f"}, 1'b0, op, 1'b1, 1'b0, B_LM | B_IW | B_PCW);
`endif
   endtask

   task automatic mem(input string tag, input logic [3:0] op, input int nwait,
                      input logic [17:0] wexp, input logic [17:0] dexp);
`ifndef CU_SYNC_MEM_EN
      for (int i = 0; i < nwait; i++)
         step({tag, "_mw"}, 1'b0, op, 1'b0, 1'b0, wexp);
`endif
      step({tag, "_m"}, 1'b0, op, 1'b1, 1'b0, dexp);
   endtask

   task automatic instr(input string tag, input logic [3:0] op,
                        input logic perf, input logic [17:0] exp);
      fetch(tag, op, 0);
      step({tag, "_x"}, 1'b0, op, 1'b1, perf, exp);
   endtask

   initial begin
      step("rst0", 1'b1, 4'h8, 1'b1, 1'b0, 18'h0);
      step("rst1", 1'b1, 4'h8, 1'b1, 1'b0, 18'h0);
      fetch("wait3", 4'h1, 3);
      step("add_x", 1'b0, 4'h1, 1'b0, 1'b0, B_RW | B_FU);
      instr("sub", 4'h2, 1'b0, B_RW | B_FU | alu(3'b001));
      instr("and", 4'h3, 1'b0, B_RW | B_FU | alu(3'b010));
      instr("or", 4'h4, 1'b0, B_RW | B_FU | alu(3'b011));
      instr("addi", 4'h5, 1'b0, B_RW | B_FU | B_SRCB);
      instr("shl", 4'h6, 1'b0, B_RW | B_FU | B_SRCB | alu(3'b101));
      instr("li", 4'h7, 1'b0, B_RW | rws(3'b010));
      instr("nop", 4'h0, 1'b1, 18'h0);
      instr("sw", 4'h9, 1'b0, B_MW | B_IORD | B_SRCB);
      instr("br0", 4'hA, 1'b0, B_JMP);
      instr("br1", 4'hA, 1'b1, B_JMP | B_PCW);
      instr("j", 4'hB, 1'b0, B_JMP | B_PCW);
      instr("call", 4'hC, 1'b0,
            B_MW | B_SPA | B_MSRC | B_SPW | alu(3'b001) | B_PCW | B_JMP);
      instr("push", 4'hE, 1'b0, B_MW | B_SPA | B_SPW | alu(3'b001));
      instr("lw", 4'h8, 1'b0, B_SRCB);
      mem("lw", 4'h8, 1, B_LM | B_IORD | B_SRCB,
          B_LM | B_IORD | B_SRCB | B_RW | rws(3'b001));
      instr("ret", 4'hD, 1'b0, B_SPW);
      mem("ret", 4'hD, 2, B_LM | B_SPA, B_LM | B_SPA | B_PCW | B_JMP);
      instr("pop", 4'hF, 1'b0, B_SPW);
      mem("pop", 4'hF, 0, B_LM | B_SPA, B_LM | B_SPA | B_RW | rws(3'b001));
      instr("lw2", 4'h8, 1'b0, B_SRCB);
`ifdef CU_SYNC_MEM_EN
      step("midrst", 1'b1, 4'h8, 1'b1, 1'b0, 18'h0);
`else
      step("lw2_mw", 1'b0, 4'h8, 1'b0, 1'b0, B_LM | B_IORD | B_SRCB);
      step("midrst", 1'b1, 4'h8, 1'b1, 1'b0, 18'h0);
`endif
      fetch("post", 4'h1, 0);
      step("post_x", 1'b0, 4'h1, 1'b1, 1'b0, B_RW | B_FU);
      step("back", 1'b0, 4'h1, 1'b0, 1'b0,
`ifdef CU_SYNC_MEM_EN
           B_LM | B_IW | B_PCW);
`else
           B_LM);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
